ring_phase_tracker: RTL and testbench
=====================================

RING_PHASE_TRACKER -- requirements
Module: ring_phase_tracker

Interface
REQ-001 Parameter N, default 4: width of the one-hot phase bus; N >= 2.
REQ-002 Parameter CW, default 8: width of the revolution counter.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: same enable that drives the upstream ring counter; 1 means the ring advances on this edge.
REQ-006 Port phase, input, N: ring counter state output (q), same clock domain, no synchronizer.
REQ-007 Port clear, input, 1: synchronous clear of counter, error and lock state.
REQ-008 Port idx, output, clog2(N): binary index of the set bit in the last legal phase.
REQ-009 Port locked, output, 1: high while state is LOCK.
REQ-010 Port wrap, output, 1: one-cycle pulse per completed revolution.
REQ-011 Port revs, output, CW: revolution count, modulo 2^CW.
REQ-012 Port revs_ovf, output, 1: sticky flag, set when revs wraps from all-ones to 0.
REQ-013 Port err, output, 1: sticky flag, set when an illegal phase or sequence is detected.

Function
REQ-014 The block SHALL register phase (phase_d) and en (en_d) every cycle; all outputs SHALL be registered.
REQ-015 The state machine SHALL have exactly three states: IDLE, LOCK and ERROR.
REQ-016 IDLE: phase all-zero SHALL hold IDLE; exactly one bit set SHALL go to LOCK; two or more bits set SHALL go to ERROR.
REQ-017 LOCK, en_d=1: phase SHALL equal phase_d rotated left by one bit (bit N-1 to bit 0); any other value SHALL go to ERROR.
REQ-018 LOCK, en_d=0: phase SHALL equal phase_d; any other value SHALL go to ERROR.
REQ-019 LOCK: an all-zero or multi-hot phase SHALL go to ERROR.
REQ-020 ERROR SHALL hold until clear=1, which goes to IDLE; phase is ignored while in ERROR.
REQ-021 The transition into ERROR SHALL set err on the same edge; err SHALL clear only on clear or reset.
REQ-022 idx SHALL update only on edges where the sampled phase is legal (IDLE to LOCK, or a checked LOCK cycle); otherwise idx SHALL hold.
REQ-023 Latency: idx, locked, wrap and err SHALL reflect the phase sampled at edge k on the outputs after edge k (one registered stage).
REQ-024 A legal LOCK rotation from bit N-1 to bit 0 SHALL assert wrap for exactly one cycle and increment revs by 1.
REQ-025 revs SHALL wrap from 2^CW-1 to 0 on increment; revs_ovf SHALL be set on that same edge.
REQ-026 No other condition SHALL change revs.
REQ-027 The IDLE-to-LOCK transition SHALL NOT assert wrap or increment revs, even when the captured bit is 0.
REQ-028 clear=1 SHALL take priority over every transition on that edge: state IDLE, revs 0, revs_ovf 0, err 0, wrap 0; idx holds.
REQ-029 After clear, a legal phase on the following edge SHALL relock per REQ-016.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, idx 0, locked 0, wrap 0, revs 0, revs_ovf 0, err 0, phase_d 0, en_d 0.
REQ-031 Reset applied mid-revolution SHALL discard all history; after release, tracking SHALL restart per REQ-016.

Verification
REQ-032 Release reset with ring at 0000 and en=1 for 10 cycles; ring runs 0001,0010,0100,1000,... -> locked=1 one edge after 0001 is sampled, idx follows 0,1,2,3, wrap pulses on each 1000->0001 step, revs=1 after the first wrap.
REQ-033 While locked at 0100, drop en for 3 cycles -> phase holds, no err, idx holds at 2; raise en -> tracking resumes with no error.
REQ-034 Force phase to 0110 while locked -> err=1 and locked=0 one edge later; apply further legal phases -> err stays 1; pulse clear -> err=0, IDLE, relock on the next legal phase.
REQ-035 With CW=2, run 4 revolutions -> revs goes 1,2,3,0; revs_ovf sets on the 3->0 wrap and stays set.
REQ-036 Skip a step (0001 then 0100 with en_d=1) -> ERROR. Assert clear on the same edge as a legal wrap -> clear wins: revs=0, wrap=0.
REQ-037 Assert reset_n=0 asynchronously between edges while revs=5 -> all outputs go to reset values before the next edge.

Source files
------------

// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker
//   Watches the one-hot state of an upstream ring counter (same clock
//   domain) and checks that every step is legal. It reports:
//   - the binary index of the active phase bit,
//   - a lock indication,
//   - a one-cycle pulse for each completed revolution,
//   - a revolution counter with a sticky overflow flag,
//   - a sticky error flag.
//
// Parameters
//   N    width of the one-hot phase bus (N >= 2)
//   CW   width of the revolution counter
//
// Ports
//   clk       clock; all state updates happen on its rising edge
//   reset_n   asynchronous, active-low reset
//   en        ring-counter enable (1 = the ring advances on this edge)
//   phase     ring-counter state, N bits, one-hot when legal
//   clear     synchronous clear of the counter, error and lock state
//   idx       index of the set bit in the last legal phase
//   locked    high while tracking a legal sequence
//   wrap      one-cycle pulse for each N-1 -> 0 rotation
//   revs      revolution count, modulo 2^CW
//   revs_ovf  sticky; set when revs wraps from all-ones to zero
//   err       sticky; set when an illegal phase or sequence is seen
module ring_phase_tracker #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         phase,
    input  logic                 clear,
    output logic [$clog2(N)-1:0] idx,
    output logic                 locked,
    output logic                 wrap,
    output logic [CW-1:0]        revs,
    output logic                 revs_ovf,
    output logic                 err
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   phase_d;
    logic           en_d;

    logic           one_hot;
    logic [N-1:0]   rotated;
    logic [N-1:0]   expected;
    logic           step_ok;
    logic           is_wrap;
    logic [IW-1:0]  enc;

    // Legality checks compare this edge's phase against last edge's sample.
    // If the ring was enabled on the previous edge it must have rotated left
    // by one; otherwise it must have held its value.
    always_comb begin
        one_hot  = ($countones(phase) == 1);
        rotated  = {phase_d[N-2:0], phase_d[N-1]};
        expected = en_d ? rotated : phase_d;
        step_ok  = one_hot && (phase == expected);
        is_wrap  = en_d && phase_d[N-1] && phase[0];
    end

    // Binary encoding of the phase; only used when phase is one-hot.
    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (phase[i]) begin
                enc = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            phase_d  <= '0;
            en_d     <= 1'b0;
            idx      <= '0;
            locked   <= 1'b0;
            wrap     <= 1'b0;
            revs     <= '0;
            revs_ovf <= 1'b0;
            err      <= 1'b0;
        end else begin
            phase_d <= phase;
            en_d    <= en;
            wrap    <= 1'b0;

            // clear overrides every transition; idx keeps its last value
            if (clear) begin
                state    <= IDLE;
                locked   <= 1'b0;
                revs     <= '0;
                revs_ovf <= 1'b0;
                err      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (phase == '0) begin
                            state <= IDLE;
                        end else if (one_hot) begin
                            // Initial capture never counts as a wrap,
                            // even when the captured bit is bit 0.
                            state  <= LOCK;
                            locked <= 1'b1;
                            idx    <= enc;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end

                    LOCK: begin
                        if (step_ok) begin
                            idx <= enc;
                            if (is_wrap) begin
                                wrap <= 1'b1;
                                revs <= revs + CW'(1);
                                if (revs == '1) begin
                                    revs_ovf <= 1'b1;
                                end
                            end
                        end else begin
                            state  <= ERROR;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end

                    ERROR: begin
                        state <= ERROR;
                    end

                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_tracker.sv
// tb_ring_phase_tracker
//   Directed bench for ring_phase_tracker. Two instances share the same
//   stimulus: the default one (CW=8) and a narrow one (CW=2) used to
//   observe revolution-counter overflow.
module tb_ring_phase_tracker;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] phase;
    logic       clear;

    logic [1:0] idx;
    logic       locked;
    logic       wrap;
    logic [7:0] revs;
    logic       revs_ovf;
    logic       err;

    logic [1:0] idx2;
    logic       locked2;
    logic       wrap2;
    logic [1:0] revs2;
    logic       revs_ovf2;
    logic       err2;

    int checks;
    int failures;

    ring_phase_tracker #(.N(4), .CW(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .phase    (phase),
        .clear    (clear),
        .idx      (idx),
        .locked   (locked),
        .wrap     (wrap),
        .revs     (revs),
        .revs_ovf (revs_ovf),
        .err      (err)
    );

    ring_phase_tracker #(.N(4), .CW(2)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .phase    (phase),
        .clear    (clear),
        .idx      (idx2),
        .locked   (locked2),
        .wrap     (wrap2),
        .revs     (revs2),
        .revs_ovf (revs_ovf2),
        .err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_idx, input int e_lk,
                           input int e_wr, input int e_rv, input int e_ov, input int e_er);
        check({tag, ".idx"},      32'(idx),      32'(e_idx));
        check({tag, ".locked"},   32'(locked),   32'(e_lk));
        check({tag, ".wrap"},     32'(wrap),     32'(e_wr));
        check({tag, ".revs"},     32'(revs),     32'(e_rv));
        check({tag, ".revs_ovf"}, 32'(revs_ovf), 32'(e_ov));
        check({tag, ".err"},      32'(err),      32'(e_er));
    endtask

    // Apply inputs, take one rising edge, then settle away from the edge.
    task automatic step(input logic [3:0] p, input logic e, input logic c);
        phase = p;
        en    = e;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        en       = 1'b0;
        phase    = 4'b0000;
        clear    = 1'b0;

        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        check("reset.revs2", 32'(revs2), 0);
        reset_n = 1'b1;

        // Ring starts at zero, then runs with en=1
        step(4'b0000, 1'b1, 1'b0); chk_all("idle0",   0, 0, 0, 0, 0, 0);
        step(4'b0001, 1'b1, 1'b0); chk_all("lock0",   0, 1, 0, 0, 0, 0);
        step(4'b0010, 1'b1, 1'b0); chk_all("run1",    1, 1, 0, 0, 0, 0);
        step(4'b0100, 1'b1, 1'b0); chk_all("run2",    2, 1, 0, 0, 0, 0);
        step(4'b1000, 1'b1, 1'b0); chk_all("run3",    3, 1, 0, 0, 0, 0);
        step(4'b0001, 1'b1, 1'b0); chk_all("wrap1",   0, 1, 1, 1, 0, 0);
        step(4'b0010, 1'b1, 1'b0); chk_all("post_w1", 1, 1, 0, 1, 0, 0);

        // Hold the ring at 0100 with en low, then resume
        step(4'b0100, 1'b0, 1'b0); chk_all("hold_a",  2, 1, 0, 1, 0, 0);
        step(4'b0100, 1'b0, 1'b0); chk_all("hold_b",  2, 1, 0, 1, 0, 0);
        step(4'b0100, 1'b0, 1'b0); chk_all("hold_c",  2, 1, 0, 1, 0, 0);
        step(4'b0100, 1'b1, 1'b0); chk_all("hold_d",  2, 1, 0, 1, 0, 0);
        step(4'b1000, 1'b1, 1'b0); chk_all("resume3", 3, 1, 0, 1, 0, 0);
        step(4'b0001, 1'b1, 1'b0); chk_all("wrap2",   0, 1, 1, 2, 0, 0);

        // Multi-hot while locked, then sticky error, then clear and relock
        step(4'b0110, 1'b1, 1'b0); chk_all("multihot", 0, 0, 0, 2, 0, 1);
        step(4'b0010, 1'b1, 1'b0); chk_all("err_st1",  0, 0, 0, 2, 0, 1);
        step(4'b0100, 1'b1, 1'b0); chk_all("err_st2",  0, 0, 0, 2, 0, 1);
        step(4'b1000, 1'b1, 1'b1); chk_all("clear1",   0, 0, 0, 0, 0, 0);
        // Capture at bit 0 right after 1000 must not count as a wrap
        step(4'b0001, 1'b1, 1'b0); chk_all("relock0",  0, 1, 0, 0, 0, 0);
        step(4'b0010, 1'b1, 1'b0); chk_all("relock1",  1, 1, 0, 0, 0, 0);
        step(4'b0100, 1'b1, 1'b0); chk_all("relock2",  2, 1, 0, 0, 0, 0);
        step(4'b1000, 1'b1, 1'b0); chk_all("relock3",  3, 1, 0, 0, 0, 0);
        step(4'b0001, 1'b1, 1'b0); chk_all("wrap3",    0, 1, 1, 1, 0, 0);

        // Skipped step: 0001 then 0100 with en_d=1
        step(4'b0100, 1'b1, 1'b0); chk_all("skip",     0, 0, 0, 1, 0, 1);
        step(4'b0100, 1'b1, 1'b1); chk_all("clear2",   0, 0, 0, 0, 0, 0);
        step(4'b0100, 1'b1, 1'b0); chk_all("relock_b", 2, 1, 0, 0, 0, 0);
        step(4'b1000, 1'b1, 1'b0); chk_all("run_b3",   3, 1, 0, 0, 0, 0);
        // clear on the same edge as a legal wrap: clear wins, idx holds
        step(4'b0001, 1'b1, 1'b1); chk_all("clr_wrap", 3, 0, 0, 0, 0, 0);
        step(4'b0010, 1'b1, 1'b0); chk_all("relock_c", 1, 1, 0, 0, 0, 0);

        // Five revolutions: the CW=2 instance goes 1,2,3,0,1 and its
        // overflow flag sets on the 3->0 wrap and stays set
        for (int r = 1; r <= 5; r++) begin
            step(4'b0100, 1'b1, 1'b0); chk_all($sformatf("rev%0d_2", r), 2, 1, 0, r - 1, 0, 0);
            step(4'b1000, 1'b1, 1'b0); chk_all($sformatf("rev%0d_3", r), 3, 1, 0, r - 1, 0, 0);
            step(4'b0001, 1'b1, 1'b0); chk_all($sformatf("rev%0d_0", r), 0, 1, 1, r, 0, 0);
            check($sformatf("rev%0d.revs2", r), 32'(revs2), 32'(r % 4));
            check($sformatf("rev%0d.ovf2", r), 32'(revs_ovf2), (r >= 4) ? 1 : 0);
            check($sformatf("rev%0d.wrap2", r), 32'(wrap2), 1);
            step(4'b0010, 1'b1, 1'b0); chk_all($sformatf("rev%0d_1", r), 1, 1, 0, r, 0, 0);
        end

        // Asynchronous reset between edges while revs=5
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst.revs2", 32'(revs2), 0);
        check("async_rst.ovf2", 32'(revs_ovf2), 0);
        #2;
        reset_n = 1'b1;

        // Tracking restarts from scratch at whatever phase is seen first
        step(4'b0100, 1'b1, 1'b0); chk_all("post_rst2", 2, 1, 0, 0, 0, 0);
        step(4'b1000, 1'b1, 1'b0); chk_all("post_rst3", 3, 1, 0, 0, 0, 0);
        step(4'b0001, 1'b1, 1'b0); chk_all("post_rstw", 0, 1, 1, 1, 0, 0);
        // All-zero phase while locked is illegal
        step(4'b0000, 1'b1, 1'b0); chk_all("zero_lock", 0, 0, 0, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
